banked_capture_ram: RTL and testbench

- Parametrised sample-capture memory for the logic analyzer.
- Built from NUM_BANKS block-RAM banks with a shared address space.
- Write side: an internal circular write pointer plus a sticky wrap flag, so the capture engine streams samples without supplying addresses.
- Read side: random-access, registered, fixed latency with a valid strobe, used by the readout and host interface.

---
 rtl/banked_capture_ram.sv | 119 +++++++++++
 tb/tb_banked_capture_ram.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/banked_capture_ram.sv
// Banked sample-capture RAM: circular write pointer with sticky wrap flag, 2-cycle registered reads.
// Optional macro RD_RELATIVE_EN makes RD_ADDR relative to the oldest sample once wrapped.
module banked_capture_ram #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH_LOG2 = 13,
  parameter int unsigned BANK_LOG2  = 11
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [DATA_W-1:0]     i_wr_data,
  input  logic                  i_wr_ptr_clr,
  output logic [DEPTH_LOG2-1:0] o_wr_ptr,
  output logic                  o_wrapped,
  input  logic                  i_rd_en,
  input  logic [DEPTH_LOG2-1:0] i_rd_addr,
  output logic [DATA_W-1:0]     o_rd_data,
  output logic                  o_rd_valid
);

  localparam int unsigned NUM_BANKS  = 1 << (DEPTH_LOG2 - BANK_LOG2);
  localparam int unsigned BANK_DEPTH = 1 << BANK_LOG2;
  localparam int unsigned SEL_W      = (DEPTH_LOG2 > BANK_LOG2) ? (DEPTH_LOG2 - BANK_LOG2) : 1;

  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic                  r_wrapped;
  logic                  w_wr_fire;
  logic [DEPTH_LOG2-1:0] w_rd_phys;
  logic [SEL_W-1:0]      w_wr_bank;
  logic [SEL_W-1:0]      w_rd_bank;
  logic                  r_s1_valid;
  logic [SEL_W-1:0]      r_s1_bank;
  logic [DATA_W-1:0]     w_bank_dout [NUM_BANKS];
  logic [DATA_W-1:0]     w_rd_mux;
  logic [DATA_W-1:0]     r_rd_data;
  logic                  r_rd_valid;

  // Clear wins over a write; no memory update while clearing or in reset.
  assign w_wr_fire = i_wr_en && !i_wr_ptr_clr && !i_rst;

`ifdef RD_RELATIVE_EN
  assign w_rd_phys = i_rd_addr + (r_wrapped ? r_wr_ptr : '0);
`else
  assign w_rd_phys = i_rd_addr;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr  <= '0;
      r_wrapped <= 1'b0;
    end else if (i_wr_ptr_clr) begin
      r_wr_ptr  <= '0;
      r_wrapped <= 1'b0;
    end else if (i_wr_en) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
      if (r_wr_ptr == '1) begin
        r_wrapped <= 1'b1;
      end
    end
  end

  generate
    if (NUM_BANKS > 1) begin : g_sel
      assign w_wr_bank = r_wr_ptr[DEPTH_LOG2-1:BANK_LOG2];
      assign w_rd_bank = w_rd_phys[DEPTH_LOG2-1:BANK_LOG2];
      assign w_rd_mux  = w_bank_dout[r_s1_bank];
    end else begin : g_nosel
      assign w_wr_bank = '0;
      assign w_rd_bank = '0;
      assign w_rd_mux  = w_bank_dout[0];
    end
  endgenerate

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [DATA_W-1:0] r_mem [BANK_DEPTH];
    logic [DATA_W-1:0] r_dout;
    logic              w_we;
    logic              w_re;

    assign w_we = w_wr_fire && (w_wr_bank == SEL_W'(g));
    assign w_re = i_rd_en && (w_rd_bank == SEL_W'(g));

    // Simple dual-port block RAM; non-blocking update gives read-first behaviour.
    always_ff @(posedge i_clk) begin
      if (w_we) begin
        r_mem[r_wr_ptr[BANK_LOG2-1:0]] <= i_wr_data;
      end
      if (w_re) begin
        r_dout <= r_mem[w_rd_phys[BANK_LOG2-1:0]];
      end
    end

    assign w_bank_dout[g] = r_dout;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_bank  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_s1_valid <= i_rd_en;
      if (i_rd_en) begin
        r_s1_bank <= w_rd_bank;
      end
      r_rd_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_rd_data <= w_rd_mux;
      end
    end
  end

  assign o_wr_ptr   = r_wr_ptr;
  assign o_wrapped  = r_wrapped;
  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;

endmodule

// File: tb/tb_banked_capture_ram.sv
// Directed, table-driven bench for banked_capture_ram (8-bit samples, 8192 deep, 2048-deep banks).
// Build with +define+RD_RELATIVE_EN to also exercise relative read addressing.
module tb_banked_capture_ram;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 13;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          wr_ptr_clr;
  logic [AW-1:0] wr_ptr;
  logic          wrapped;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } vec_t;

  vec_t vecs [10];

  banked_capture_ram #(
    .DATA_W    (DW),
    .DEPTH_LOG2(AW),
    .BANK_LOG2 (11)
  ) u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wr_en     (wr_en),
    .i_wr_data   (wr_data),
    .i_wr_ptr_clr(wr_ptr_clr),
    .o_wr_ptr    (wr_ptr),
    .o_wrapped   (wrapped),
    .i_rd_en     (rd_en),
    .i_rd_addr   (rd_addr),
    .o_rd_data   (rd_data),
    .o_rd_valid  (rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] fill_val(input logic [AW-1:0] a);
    return a[7:0] ^ {3'b000, a[12:8]};
  endfunction

  task automatic clear_ptr();
    wr_ptr_clr = 1'b1;
    tick();
    wr_ptr_clr = 1'b0;
  endtask

  task automatic write_one(input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_one(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    check({name, "_nvalid1"}, {31'd0, rd_valid}, 32'd0);
    tick();
    check({name, "_valid"}, {31'd0, rd_valid}, 32'd1);
    check({name, "_data"}, {24'd0, rd_data}, {24'd0, exp});
  endtask

  initial begin
    vecs[0] = '{addr: 13'd2047, data: 8'hF8};
    vecs[1] = '{addr: 13'd2048, data: 8'h08};
    vecs[2] = '{addr: 13'd4095, data: 8'hF0};
    vecs[3] = '{addr: 13'd4096, data: 8'h10};
    vecs[4] = '{addr: 13'd6143, data: 8'hE8};
    vecs[5] = '{addr: 13'd6144, data: 8'h18};
    vecs[6] = '{addr: 13'd0,    data: 8'h00};
    vecs[7] = '{addr: 13'd8191, data: 8'hE0};
    vecs[8] = '{addr: 13'd100,  data: 8'h64};
    vecs[9] = '{addr: 13'd10,   data: 8'h0A};

    rst = 1'b1; wr_en = 1'b0; wr_data = '0; wr_ptr_clr = 1'b0; rd_en = 1'b0; rd_addr = '0;
    #1;
    check("rst_wr_ptr", {19'd0, wr_ptr}, 32'd0);
    check("rst_wrapped", {31'd0, wrapped}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_rd_data", {24'd0, rd_data}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Fill the whole memory; the last write wraps the pointer.
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        check("fill_ptr_last", {19'd0, wr_ptr}, 32'd8191);
        check("fill_wrapped_before", {31'd0, wrapped}, 32'd0);
      end
      wr_en   = 1'b1;
      wr_data = fill_val(AW'(i));
      tick();
    end
    wr_en = 1'b0;
    check("fill_ptr_wrap", {19'd0, wr_ptr}, 32'd0);
    check("fill_wrapped", {31'd0, wrapped}, 32'd1);

    // Back-to-back read of every address; results trail requests by 2 cycles.
    for (int i = 0; i <= DEPTH; i++) begin
      rd_en   = (i < DEPTH);
      rd_addr = AW'(i);
      tick();
      if (i >= 1) begin
        check($sformatf("fill_rd_valid[%0d]", i - 1), {31'd0, rd_valid}, 32'd1);
        check($sformatf("fill_rd_data[%0d]", i - 1), {24'd0, rd_data},
              {24'd0, fill_val(AW'(i - 1))});
      end
    end
    rd_en = 1'b0;
    tick();
    check("fill_rd_valid_drop", {31'd0, rd_valid}, 32'd0);

    // Clear priority: pointer at 100, clear + write of 0xAA together.
    clear_ptr();
    for (int i = 0; i < 100; i++) write_one(fill_val(AW'(i)));
    check("clr_pre_ptr", {19'd0, wr_ptr}, 32'd100);
    wr_en = 1'b1; wr_ptr_clr = 1'b1; wr_data = 8'hAA;
    tick();
    wr_en = 1'b0; wr_ptr_clr = 1'b0;
    check("clr_ptr", {19'd0, wr_ptr}, 32'd0);
    check("clr_wrapped", {31'd0, wrapped}, 32'd0);

    // Bank-boundary table, issued back to back (entry 8 confirms mem[100] kept 0x64).
    for (int i = 0; i <= 10; i++) begin
      rd_en   = (i < 10);
      rd_addr = (i < 10) ? vecs[i].addr : '0;
      tick();
      if (i >= 1) begin
        check($sformatf("tbl_valid[%0d]", i - 1), {31'd0, rd_valid}, 32'd1);
        check($sformatf("tbl_data[%0d]", i - 1), {24'd0, rd_data}, {24'd0, vecs[i - 1].data});
      end
    end
    rd_en = 1'b0;
    tick();
    check("tbl_valid_drop", {31'd0, rd_valid}, 32'd0);
    check("tbl_data_hold", {24'd0, rd_data}, {24'd0, vecs[9].data});

    // Read-during-write on address 10 returns the old value.
    clear_ptr();
    for (int i = 0; i < 10; i++) write_one(fill_val(AW'(i)));
    write_one(8'h33);
    clear_ptr();
    for (int i = 0; i < 10; i++) write_one(fill_val(AW'(i)));
    check("rdw_ptr", {19'd0, wr_ptr}, 32'd10);
    wr_en = 1'b1; wr_data = 8'h55; rd_en = 1'b1; rd_addr = 13'd10;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    tick();
    check("rdw_valid", {31'd0, rd_valid}, 32'd1);
    check("rdw_old", {24'd0, rd_data}, 32'h33);
    read_one("rdw_new", 13'd10, 8'h55);

    // Asynchronous reset with a read in flight.
    rd_en = 1'b1; rd_addr = 13'd5;
    tick();
    rd_en = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_wr_ptr", {19'd0, wr_ptr}, 32'd0);
    check("arst_wrapped", {31'd0, wrapped}, 32'd0);
    check("arst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("arst_rd_data", {24'd0, rd_data}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("arst_no_valid1", {31'd0, rd_valid}, 32'd0);
    tick();
    check("arst_no_valid2", {31'd0, rd_valid}, 32'd0);
    read_one("post_rst_rd", 13'd2048, 8'h08);

`ifdef RD_RELATIVE_EN
    clear_ptr();
    for (int i = 0; i < DEPTH + 5; i++) begin
      wr_en   = 1'b1;
      wr_data = DW'(i);
      tick();
    end
    wr_en = 1'b0;
    check("rel_ptr", {19'd0, wr_ptr}, 32'd5);
    check("rel_wrapped", {31'd0, wrapped}, 32'd1);
    read_one("rel_oldest", 13'd0, 8'h05);
    read_one("rel_newest", 13'd8191, 8'h04);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
